xfifo_flow: RTL and testbench

Parametrised successor FIFO for the packet-routing datapath: dual-pointer circular buffer with internal storage, explicit occupancy count, programmable almost-full/almost-empty thresholds, registered read data with a valid strobe, and separate sticky overflow/underflow errors with software clear. It sits between the input classifier and the per-destination arbiters. The upper DEST_BITS of each word are the routing destination.

---
 rtl/xfifo_flow_if.sv | 42 ++++
 rtl/xfifo_flow.sv | 101 ++++++++++
 tb/tb_xfifo_flow.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/xfifo_flow_if.sv
// Port bundle for the xfifo_flow routing FIFO: write/read requests, thresholds,
// error clear, and the read data / occupancy / error status returned.
interface xfifo_flow_if #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3,
    parameter int DEST_BITS = 2
);
    logic [DATA_BITS-1:0] fifo_data_in;
    logic                 fifo_write;
    logic                 fifo_read;
    logic [ADDR_BITS:0]   high_limit;
    logic [ADDR_BITS:0]   low_limit;
    logic                 error_clear;

    logic [DATA_BITS-1:0] fifo_data_out;
    logic [DEST_BITS-1:0] destino;
    logic                 data_valid;
    logic                 full;
    logic                 empty;
    logic                 fifo_full_out;
    logic                 fifo_empty_out;
    logic [ADDR_BITS:0]   fifo_count;
    logic                 overflow_err;
    logic                 underflow_err;
    logic                 error_fifo_out;

    // Handshake: a write is taken on a rising edge when fifo_write is high and the
    // FIFO is not full (or a read is taken in the same edge); a read is taken when
    // fifo_read is high and the FIFO is not empty, and its word appears on
    // fifo_data_out with data_valid high for exactly the following cycle.
    modport master (
        output fifo_data_in, fifo_write, fifo_read, high_limit, low_limit, error_clear,
        input  fifo_data_out, destino, data_valid, full, empty, fifo_full_out,
               fifo_empty_out, fifo_count, overflow_err, underflow_err, error_fifo_out
    );

    modport slave (
        input  fifo_data_in, fifo_write, fifo_read, high_limit, low_limit, error_clear,
        output fifo_data_out, destino, data_valid, full, empty, fifo_full_out,
               fifo_empty_out, fifo_count, overflow_err, underflow_err, error_fifo_out
    );
endinterface

// File: rtl/xfifo_flow.sv
// Circular-buffer FIFO between the input classifier and the per-destination arbiters,
// with registered read data, occupancy thresholds and sticky overflow/underflow errors.
module xfifo_flow #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3,
    parameter int DEST_BITS = 2
) (
    input  logic         clk,
    input  logic         reset,
    xfifo_flow_if.slave  bus
);
    localparam int SIZE = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(SIZE);
    localparam logic [ADDR_BITS:0] PTR_ONE  = (ADDR_BITS + 1)'(1);

    logic [DATA_BITS-1:0] mem_q [SIZE];

    logic [ADDR_BITS:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic [ADDR_BITS:0]   count;
    logic                 full;
    logic                 empty;
    logic                 rd_acc;
    logic                 wr_acc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count  = wr_ptr_q - rd_ptr_q;
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign rd_acc = bus.fifo_read & ~empty;
    assign wr_acc = bus.fifo_write & (~full | rd_acc);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q & ~bus.error_clear;
        unf_d      = unf_q & ~bus.error_clear;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = mem_q[rd_ptr_q[ADDR_BITS-1:0]];
            valid_d    = 1'b1;
        end

        // A fresh error in the same cycle as error_clear keeps the flag set.
        if (bus.fifo_write & full & ~bus.fifo_read) begin
            ovf_d = 1'b1;
        end
        if (bus.fifo_read & empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage needs no reset: a slot is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_BITS-1:0]] <= bus.fifo_data_in;
        end
    end

    assign bus.fifo_data_out  = data_out_q;
    assign bus.destino        = data_out_q[DATA_BITS-1 -: DEST_BITS];
    assign bus.data_valid     = valid_q;
    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.fifo_count     = count;
    assign bus.fifo_full_out  = full | ((bus.high_limit != '0) & (count >= bus.high_limit));
    assign bus.fifo_empty_out = empty | ((bus.low_limit != '0) & (count <= bus.low_limit));
    assign bus.overflow_err   = ovf_q;
    assign bus.underflow_err  = unf_q;
    assign bus.error_fifo_out = ovf_q | unf_q;

endmodule

// File: tb/tb_xfifo_flow.sv
// Directed bench for xfifo_flow: a queue-based model checked every cycle, plus
// hand-computed literal expectations at the points of interest.
module tb_xfifo_flow;
  localparam int DW = 10;
  localparam int AW = 3;
  localparam int DB = 2;
  localparam int SIZE = 1 << AW;

  logic clk;
  logic reset;

  xfifo_flow_if #(.DATA_BITS(DW), .ADDR_BITS(AW), .DEST_BITS(DB)) bus ();

  xfifo_flow #(.DATA_BITS(DW), .ADDR_BITS(AW), .DEST_BITS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  bit run_cmp = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      bit was_empty, was_full, take_rd, take_wr;
      was_empty = (exp_q.size() == 0);
      was_full  = (exp_q.size() == SIZE);
      take_rd   = bus.fifo_read && !was_empty;
      take_wr   = bus.fifo_write && (!was_full || take_rd);
      m_ovf = (bus.fifo_write && was_full && !bus.fifo_read) || (m_ovf && !bus.error_clear);
      m_unf = (bus.fifo_read && was_empty) || (m_unf && !bus.error_clear);
      m_valid = take_rd;
      if (take_rd) m_dout = exp_q.pop_front();
      if (take_wr) exp_q.push_back(bus.fifo_data_in);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_cmp) begin
      int cnt;
      int hl, ll;
      cnt = exp_q.size();
      hl = int'(bus.high_limit);
      ll = int'(bus.low_limit);
      chk("cyc_count", 32'(bus.fifo_count), 32'(cnt));
      chk("cyc_full", 32'(bus.full), 32'(cnt == SIZE));
      chk("cyc_empty", 32'(bus.empty), 32'(cnt == 0));
      chk("cyc_almost_full", 32'(bus.fifo_full_out), 32'((cnt == SIZE) || (hl != 0 && cnt >= hl)));
      chk("cyc_almost_empty", 32'(bus.fifo_empty_out), 32'((cnt == 0) || (ll != 0 && cnt <= ll)));
      chk("cyc_valid", 32'(bus.data_valid), 32'(m_valid));
      chk("cyc_data", 32'(bus.fifo_data_out), 32'(m_dout));
      chk("cyc_destino", 32'(bus.destino), 32'(m_dout / (1 << (DW - DB))));
      chk("cyc_ovf", 32'(bus.overflow_err), 32'(m_ovf));
      chk("cyc_unf", 32'(bus.underflow_err), 32'(m_unf));
      chk("cyc_err", 32'(bus.error_fifo_out), 32'(m_ovf || m_unf));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic clr);
    bus.fifo_write   = w;
    bus.fifo_read    = r;
    bus.fifo_data_in = d;
    bus.error_clear  = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(bus.fifo_count), 0);
    chk({tag, "_empty"}, 32'(bus.empty), 1);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_aempty"}, 32'(bus.fifo_empty_out), 1);
    chk({tag, "_afull"}, 32'(bus.fifo_full_out), 0);
    chk({tag, "_data"}, 32'(bus.fifo_data_out), 0);
    chk({tag, "_destino"}, 32'(bus.destino), 0);
    chk({tag, "_valid"}, 32'(bus.data_valid), 0);
    chk({tag, "_err"}, 32'({bus.overflow_err, bus.underflow_err, bus.error_fifo_out}), 0);
  endtask

  // ---------------- directed stimulus ----------------
  logic [DW-1:0] wrap_w [23];

  initial begin
    reset = 1'b0;
    bus.fifo_write = 1'b0;
    bus.fifo_read = 1'b0;
    bus.fifo_data_in = '0;
    bus.high_limit = '0;
    bus.low_limit = '0;
    bus.error_clear = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_vals("rst");
    reset = 1'b1;
    run_cmp = 1;

    // Fill to full, then one overflowing write.
    for (int i = 1; i <= 8; i++) step(1, 0, DW'(i), 0);
    chk("fill_count", 32'(bus.fifo_count), 8);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_afull", 32'(bus.fifo_full_out), 1);
    chk("fill_err", 32'(bus.error_fifo_out), 0);
    step(1, 0, 10'h009, 0);
    chk("ovf_flag", 32'(bus.overflow_err), 1);
    chk("ovf_count", 32'(bus.fifo_count), 8);

    // Drain in order, then one underflowing read.
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, '0, 0);
      chk("drain_valid", 32'(bus.data_valid), 1);
      chk("drain_data", 32'(bus.fifo_data_out), 32'(i));
      chk("drain_destino", 32'(bus.destino), 0);
    end
    step(0, 1, '0, 0);
    chk("unf_flag", 32'(bus.underflow_err), 1);
    chk("unf_hold", 32'(bus.fifo_data_out), 32'h008);
    chk("unf_valid", 32'(bus.data_valid), 0);
    step(0, 0, '0, 1);
    chk("clr_err", 32'(bus.error_fifo_out), 0);

    // Programmable thresholds.
    bus.high_limit = 4'd5;
    bus.low_limit = 4'd2;
    for (int i = 0; i < 4; i++) step(1, 0, DW'(10'h040 + i), 0);
    chk("hl_at4", 32'(bus.fifo_full_out), 0);
    step(1, 0, 10'h044, 0);
    chk("hl_at5", 32'(bus.fifo_full_out), 1);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    chk("ll_at3", 32'(bus.fifo_empty_out), 0);
    chk("ll_data", 32'(bus.fifo_data_out), 32'h041);
    step(0, 1, '0, 0);
    chk("ll_at2", 32'(bus.fifo_empty_out), 1);
    bus.high_limit = 4'd9;
    step(0, 1, '0, 0);
    chk("hl_over_size", 32'(bus.fifo_full_out), 0);
    bus.high_limit = '0;
    bus.low_limit = '0;
    step(0, 1, '0, 0);
    chk("thr_empty", 32'(bus.empty), 1);

    // Simultaneous write+read on full and on empty.
    for (int i = 0; i < 8; i++) step(1, 0, DW'(10'h300 + i), 0);
    step(1, 1, 10'h2AA, 0);
    chk("fullrw_count", 32'(bus.fifo_count), 8);
    chk("fullrw_ovf", 32'(bus.overflow_err), 0);
    chk("fullrw_data", 32'(bus.fifo_data_out), 32'h300);
    chk("fullrw_destino", 32'(bus.destino), 3);
    for (int i = 0; i < 8; i++) step(0, 1, '0, 0);
    chk("fullrw_last", 32'(bus.fifo_data_out), 32'h2AA);
    chk("fullrw_last_dest", 32'(bus.destino), 2);
    step(1, 1, 10'h155, 0);
    chk("emptyrw_count", 32'(bus.fifo_count), 1);
    chk("emptyrw_unf", 32'(bus.underflow_err), 1);
    chk("emptyrw_nobypass", 32'(bus.data_valid), 0);
    step(0, 1, '0, 1);
    chk("emptyrw_read", 32'(bus.fifo_data_out), 32'h155);
    chk("emptyrw_valid", 32'(bus.data_valid), 1);
    chk("emptyrw_clr", 32'(bus.underflow_err), 0);

    // Pointer wrap at steady occupancy 3.
    for (int i = 0; i < 23; i++) wrap_w[i] = DW'((i % 4) * 256 + i * 3 + 1);
    for (int i = 0; i < 3; i++) step(1, 0, wrap_w[i], 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, wrap_w[i + 3], 0);
      chk("wrap_count", 32'(bus.fifo_count), 3);
      chk("wrap_data", 32'(bus.fifo_data_out), 32'(wrap_w[i]));
    end
    for (int i = 0; i < 3; i++) step(0, 1, '0, 0);
    chk("wrap_tail", 32'(bus.fifo_data_out), 32'(wrap_w[22]));

    // Clear coinciding with a fresh underflow, then clear alone.
    step(0, 1, '0, 1);
    chk("clr_race", 32'(bus.underflow_err), 1);
    step(0, 0, '0, 1);
    chk("clr_alone", 32'(bus.underflow_err), 0);

    // Asynchronous reset in the middle of a write burst.
    step(1, 0, 10'h0A1, 0);
    step(1, 0, 10'h0A2, 0);
    step(0, 1, '0, 0);
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    bus.fifo_write = 1'b0;
    bus.fifo_read = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    step(1, 0, 10'h3FF, 0);
    chk("post_rst_count", 32'(bus.fifo_count), 1);
    step(0, 1, '0, 0);
    chk("post_rst_data", 32'(bus.fifo_data_out), 32'h3FF);
    chk("post_rst_destino", 32'(bus.destino), 3);
    step(0, 0, '0, 0);

    run_cmp = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound in case the clock or stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
